// File: rtl/sgm_path_aggregator.sv
// SGM path cost aggregation stage.
// For every disparity d in one beat it computes
//   L(d) = C(d) + min(L'(d), L'(d-1)+P1, L'(d+1)+P1, minL'+P2eff) - minL'
// with saturation to the accumulator width. L' and minL' come from the result
// PATH_DELAY valid beats earlier, so the same block serves horizontal, vertical
// and diagonal paths.
module sgm_path_aggregator #(
    parameter int DISPARITY_LEVELS = 64,
    parameter int COST_BITS        = 6,
    parameter int ACC_COST_BITS    = 10,
    parameter int P_BITS           = 8,
    parameter int PATH_DELAY       = 1
) (
    input  logic                                  in_clk,
    input  logic                                  in_rst,
    input  logic                                  in_de,
    input  logic                                  in_path_beginning,
    input  logic [P_BITS-1:0]                     in_P1,
    input  logic [P_BITS-1:0]                     in_P2,
    input  logic [COST_BITS*DISPARITY_LEVELS-1:0] in_C_arr,
    output logic                                  out_valid,
    output logic [ACC_COST_BITS*DISPARITY_LEVELS-1:0] out_L_arr,
    output logic [ACC_COST_BITS-1:0]              out_L_min,
    output logic                                  out_sat
);

    localparam int D   = DISPARITY_LEVELS;
    localparam int ACC = ACC_COST_BITS;
    // Wide enough for minL' + P2 + C without wrapping.
    localparam int W   = ACC_COST_BITS + P_BITS + 1;
    localparam int MW  = ACC_COST_BITS * (DISPARITY_LEVELS + 1);
    localparam logic [W-1:0] L_MAX = {{(W-ACC){1'b0}}, {ACC{1'b1}}};

    // Reject parameter sets the datapath cannot represent.
    if (ACC_COST_BITS < COST_BITS) begin : g_bad_acc
        $error("ACC_COST_BITS must be >= COST_BITS");
    end
    if (PATH_DELAY < 1) begin : g_bad_delay
        $error("PATH_DELAY must be >= 1");
    end
    if (DISPARITY_LEVELS < 2) begin : g_bad_levels
        $error("DISPARITY_LEVELS must be >= 2");
    end

    logic                 valid_q, valid_d;
    logic [ACC*D-1:0]     l_arr_q, l_arr_d;
    logic [ACC-1:0]       l_min_q, l_min_d;
    logic                 sat_q, sat_d;

    logic [ACC*D-1:0]     prev_l;
    logic [ACC-1:0]       prev_min;

    logic [ACC*D-1:0]     l_arr_new;
    logic [ACC-1:0]       l_min_new;
    logic                 sat_new;

    logic [W-1:0]         prev_w [D];

    // Predecessor source: the output register itself for horizontal paths,
    // otherwise a circular buffer holding the last PATH_DELAY results.
    if (PATH_DELAY == 1) begin : g_direct
        assign prev_l   = l_arr_q;
        assign prev_min = l_min_q;
    end else begin : g_mem
        localparam int PW = $clog2(PATH_DELAY);

        logic [MW-1:0] delay_mem [PATH_DELAY];
        logic [PW-1:0] ptr_q, ptr_d;

        // Pointer advances once per valid beat and wraps at PATH_DELAY-1.
        always_comb begin
            ptr_d = ptr_q;
            if (in_de) begin
                ptr_d = (ptr_q == PW'(PATH_DELAY - 1)) ? '0 : ptr_q + PW'(1);
            end
        end

        // Pointer register.
        always_ff @(posedge in_clk) begin
            if (in_rst) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end

        // Store each result at the slot just read: the slot is read during
        // the beat and overwritten at its closing edge.
        // NOTE: the buffer is deliberately not reset; paths restart with
        // in_path_beginning, so stale contents are never consumed.
        always_ff @(posedge in_clk) begin
            if (!in_rst && in_de) begin
                delay_mem[ptr_q] <= {l_min_new, l_arr_new};
            end
        end

        assign {prev_min, prev_l} = delay_mem[ptr_q];
    end

    // Path cost update for all disparities, with saturation and minimum.
    always_comb begin
        logic [W-1:0] p1_w;
        logic [W-1:0] p2_w;
        logic [W-1:0] min_w;
        logic [W-1:0] cost_w;
        logic [W-1:0] s_w;
        logic [W-1:0] cand_w;
        logic [W-1:0] sum_w;
        logic [ACC-1:0] l_d;
        // NOTE: every combinational output gets a default before any branch,
        // so no path through the block leaves it unassigned (no latch).
        p1_w      = W'(in_P1);
        p2_w      = (in_P2 > in_P1) ? W'(in_P2) : W'(in_P1);
        min_w     = W'(prev_min);
        cost_w    = '0;
        s_w       = '0;
        cand_w    = '0;
        sum_w     = '0;
        l_d       = '0;
        l_arr_new = '0;
        l_min_new = '1;
        sat_new   = 1'b0;

        for (int d = 0; d < D; d++) begin
            prev_w[d] = W'(prev_l[ACC*d +: ACC]);
        end

        for (int d = 0; d < D; d++) begin
            cost_w = W'(in_C_arr[COST_BITS*d +: COST_BITS]);
            s_w    = prev_w[d];
            cand_w = min_w + p2_w;
            if (cand_w < s_w) s_w = cand_w;
            if (d > 0) begin
                cand_w = prev_w[(d == 0) ? 0 : d - 1] + p1_w;
                if (cand_w < s_w) s_w = cand_w;
            end
            if (d < D - 1) begin
                cand_w = prev_w[(d == D - 1) ? D - 1 : d + 1] + p1_w;
                if (cand_w < s_w) s_w = cand_w;
            end
            sum_w = cost_w + s_w - min_w;

            if (in_path_beginning) begin
                l_d = ACC'(cost_w);
            end else if (sum_w > L_MAX) begin
                l_d     = '1;
                sat_new = 1'b1;
            end else begin
                l_d = sum_w[ACC-1:0];
            end

            l_arr_new[ACC*d +: ACC] = l_d;
            if (l_d < l_min_new) l_min_new = l_d;
        end
    end

    // Output register next state: load on a valid beat, hold otherwise.
    always_comb begin
        valid_d = in_de;
        l_arr_d = l_arr_q;
        l_min_d = l_min_q;
        sat_d   = sat_q;
        if (in_de) begin
            l_arr_d = l_arr_new;
            l_min_d = l_min_new;
            sat_d   = sat_new;
        end
    end

    // Output registers with synchronous reset.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            valid_q <= 1'b0;
            l_arr_q <= '0;
            l_min_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            l_arr_q <= l_arr_d;
            l_min_q <= l_min_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid = valid_q;
    assign out_L_arr = l_arr_q;
    assign out_L_min = l_min_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_sgm_path_aggregator.sv
// Directed bench for sgm_path_aggregator. Three instances, all with four
// disparities and 6-bit path costs:
//   a: COST_BITS=4, PATH_DELAY=1
//   b: COST_BITS=6, PATH_DELAY=1 (saturation)
//   c: COST_BITS=4, PATH_DELAY=3 (delayed predecessor)
// Each table row is one clock cycle; sel picks the instance that is driven
// and checked, the others see in_de=0. Reset is common to all instances.
module tb_sgm_path_aggregator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        beg = 1'b0;
    logic [7:0]  p1 = '0;
    logic [7:0]  p2 = '0;
    logic        de_a = 1'b0, de_b = 1'b0, de_c = 1'b0;
    logic [15:0] c_a = '0, c_c = '0;
    logic [23:0] c_b = '0;

    logic        v_a, v_b, v_c;
    logic [23:0] l_a, l_b, l_c;
    logic [5:0]  m_a, m_b, m_c;
    logic        s_a, s_b, s_c;

    sgm_path_aggregator #(.DISPARITY_LEVELS(4), .COST_BITS(4), .ACC_COST_BITS(6),
                          .P_BITS(8), .PATH_DELAY(1)) u_a (
        .in_clk(clk), .in_rst(rst), .in_de(de_a), .in_path_beginning(beg),
        .in_P1(p1), .in_P2(p2), .in_C_arr(c_a),
        .out_valid(v_a), .out_L_arr(l_a), .out_L_min(m_a), .out_sat(s_a));

    sgm_path_aggregator #(.DISPARITY_LEVELS(4), .COST_BITS(6), .ACC_COST_BITS(6),
                          .P_BITS(8), .PATH_DELAY(1)) u_b (
        .in_clk(clk), .in_rst(rst), .in_de(de_b), .in_path_beginning(beg),
        .in_P1(p1), .in_P2(p2), .in_C_arr(c_b),
        .out_valid(v_b), .out_L_arr(l_b), .out_L_min(m_b), .out_sat(s_b));

    sgm_path_aggregator #(.DISPARITY_LEVELS(4), .COST_BITS(4), .ACC_COST_BITS(6),
                          .P_BITS(8), .PATH_DELAY(3)) u_c (
        .in_clk(clk), .in_rst(rst), .in_de(de_c), .in_path_beginning(beg),
        .in_P1(p1), .in_P2(p2), .in_C_arr(c_c),
        .out_valid(v_c), .out_L_arr(l_c), .out_L_min(m_c), .out_sat(s_c));

    typedef struct {
        logic [1:0]  sel;
        logic        rst;
        logic        de;
        logic        beg;
        logic [7:0]  p1;
        logic [7:0]  p2;
        logic [23:0] c;
        logic        ev;
        logic [23:0] el;
        logic [5:0]  emin;
        logic        es;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   bad    = 0;

    // Pack four 6-bit values, d0 in the least significant field.
    function automatic logic [23:0] pk(input int d0, input int d1, input int d2, input int d3);
        return {6'(d3), 6'(d2), 6'(d1), 6'(d0)};
    endfunction

    task automatic add(input logic [1:0] sel, input logic r, input logic de, input logic bg,
                       input int q1, input int q2, input logic [23:0] c,
                       input logic ev, input logic [23:0] el, input int emin, input logic es);
        vec_t v;
        v = '{sel, r, de, bg, 8'(q1), 8'(q2), c, ev, el, 6'(emin), es};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one row at the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        logic        av;
        logic [23:0] al;
        logic [5:0]  am;
        logic        as;
        @(negedge clk);
        rst  = v.rst;
        beg  = v.beg;
        p1   = v.p1;
        p2   = v.p2;
        de_a = v.de && (v.sel == 2'd0);
        de_b = v.de && (v.sel == 2'd1);
        de_c = v.de && (v.sel == 2'd2);
        for (int d = 0; d < 4; d++) begin
            c_a[4*d +: 4] = v.c[6*d +: 4];
            c_c[4*d +: 4] = v.c[6*d +: 4];
        end
        c_b = v.c;
        @(posedge clk);
        #1;
        case (v.sel)
            2'd0:    begin av = v_a; al = l_a; am = m_a; as = s_a; end
            2'd1:    begin av = v_b; al = l_b; am = m_b; as = s_b; end
            default: begin av = v_c; al = l_c; am = m_c; as = s_c; end
        endcase
        check({tag, " valid"}, 32'(av), 32'(v.ev));
        check({tag, " L"},     32'(al), 32'(v.el));
        check({tag, " Lmin"},  32'(am), 32'(v.emin));
        check({tag, " sat"},   32'(as), 32'(v.es));
    endtask

    initial begin
        vec_t h;

        // Reset for three cycles, observed on each instance.
        add(0, 1, 0, 0, 0, 0, pk(0,0,0,0),   0, pk(0,0,0,0), 0, 0);
        add(1, 1, 0, 0, 0, 0, pk(0,0,0,0),   0, pk(0,0,0,0), 0, 0);
        add(2, 1, 0, 0, 0, 0, pk(0,0,0,0),   0, pk(0,0,0,0), 0, 0);
        // Instance a: path start, then smoothing from a zero-cost pixel.
        add(0, 0, 1, 1, 0, 0, pk(3,5,0,7),   1, pk(3,5,0,7), 0, 0);
        add(0, 0, 1, 0, 1, 4, pk(0,0,0,0),   1, pk(3,1,0,1), 0, 0);
        // Idle cycle: valid drops, result holds.
        add(0, 0, 0, 0, 1, 4, pk(9,9,9,9),   0, pk(3,1,0,1), 0, 0);
        // P2 below P1 is raised to P1.
        add(0, 0, 1, 1, 0, 0, pk(0,10,10,10), 1, pk(0,10,10,10), 0, 0);
        add(0, 0, 1, 0, 5, 2, pk(0,0,0,0),   1, pk(0,5,5,5), 0, 0);
        // Non-zero costs, non-zero minimum, then subtraction of stored minL'.
        add(0, 0, 1, 0, 2, 7, pk(15,1,2,3),  1, pk(15,3,7,8), 3, 0);
        add(0, 0, 1, 0, 1, 2, pk(0,0,0,0),   1, pk(1,0,1,2), 0, 0);
        // Reset wins over a simultaneous valid beat; restart reproduces the start.
        add(0, 1, 1, 0, 1, 2, pk(4,4,4,4),   0, pk(0,0,0,0), 0, 0);
        add(0, 0, 1, 1, 0, 0, pk(3,5,0,7),   1, pk(3,5,0,7), 0, 0);
        add(0, 0, 1, 0, 1, 4, pk(0,0,0,0),   1, pk(3,1,0,1), 0, 0);
        // Instance b: saturation, exact-fit 63 at d0, then sat clears.
        add(1, 0, 1, 1, 0, 0, pk(0,63,63,63),   1, pk(0,63,63,63), 0, 0);
        add(1, 0, 1, 0, 60, 60, pk(63,63,63,63), 1, pk(63,63,63,63), 63, 1);
        add(1, 0, 1, 0, 1, 1, pk(0,0,0,0),       1, pk(0,0,0,0), 0, 0);
        // Instance c: de pattern 1,0,1,1,0,0,1,1 plus one more beat.
        add(2, 0, 1, 1, 15, 15, pk(0,9,2,4),  1, pk(0,9,2,4), 0, 0);
        add(2, 0, 0, 0, 15, 15, pk(0,0,0,0),  0, pk(0,9,2,4), 0, 0);
        add(2, 0, 1, 1, 15, 15, pk(6,1,8,3),  1, pk(6,1,8,3), 1, 0);
        add(2, 0, 1, 1, 15, 15, pk(5,5,0,12), 1, pk(5,5,0,12), 0, 0);
        add(2, 0, 0, 0, 15, 15, pk(0,0,0,0),  0, pk(5,5,0,12), 0, 0);
        add(2, 0, 0, 0, 15, 15, pk(0,0,0,0),  0, pk(5,5,0,12), 0, 0);
        add(2, 0, 1, 0, 15, 15, pk(1,1,1,1),  1, pk(1,10,3,5), 1, 0);
        add(2, 0, 1, 0, 15, 15, pk(2,0,0,2),  1, pk(7,0,7,4), 0, 0);
        add(2, 0, 1, 0, 15, 15, pk(0,0,0,0),  1, pk(5,5,0,12), 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Hand-written: reset instance c mid-stream with de high, then a new
        // path of three starts; the next two beats must see the first two.
        h = '{2'd2, 1'b1, 1'b1, 1'b0, 8'd15, 8'd15, pk(3,3,3,3), 1'b0, pk(0,0,0,0), 6'd0, 1'b0};
        apply(h, "c_rst");
        h = '{2'd2, 1'b0, 1'b1, 1'b1, 8'd15, 8'd15, pk(7,0,7,0), 1'b1, pk(7,0,7,0), 6'd0, 1'b0};
        apply(h, "c_beg0");
        h = '{2'd2, 1'b0, 1'b1, 1'b1, 8'd15, 8'd15, pk(1,2,3,4), 1'b1, pk(1,2,3,4), 6'd1, 1'b0};
        apply(h, "c_beg1");
        h = '{2'd2, 1'b0, 1'b1, 1'b1, 8'd15, 8'd15, pk(0,0,5,5), 1'b1, pk(0,0,5,5), 6'd0, 1'b0};
        apply(h, "c_beg2");
        h = '{2'd2, 1'b0, 1'b1, 1'b0, 8'd15, 8'd15, pk(0,0,0,0), 1'b1, pk(7,0,7,0), 6'd0, 1'b0};
        apply(h, "c_pred0");
        h = '{2'd2, 1'b0, 1'b1, 1'b0, 8'd15, 8'd15, pk(0,0,0,0), 1'b1, pk(0,1,2,3), 6'd0, 1'b0};
        apply(h, "c_pred1");

        @(negedge clk);
        de_a = 1'b0;
        de_b = 1'b0;
        de_c = 1'b0;
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
